// File: rtl/rotate_pkg.sv
// Shared constants and state encoding for the rotate core's pixel tile buffer.
package rotate_pkg;
  localparam int ADDR_W         = 8;
  localparam int DEPTH          = 2 ** ADDR_W;
  localparam int BEAT_W         = 32;
  localparam int BYTES_PER_BEAT = 4;
  localparam int LEN_W          = ADDR_W + 1;
  localparam int WORD_W         = ADDR_W - 2;
  localparam int WPTR_W         = 7;
  localparam int RD_PORTS       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_t;
endpackage

// File: rtl/core_tile_buf_if.sv
// DMA write, tile control and quad-read signals between the buffer and its neighbours.
interface core_tile_buf_if;
  import rotate_pkg::*;

  logic              I_START;
  logic [LEN_W-1:0]  I_FILL_LEN;
  logic              I_WR_VALID;
  logic [BEAT_W-1:0] I_WR_DATA;
  logic              O_WR_READY;
  logic              O_DMA_READY;
  logic              I_RD_EN;
  logic [ADDR_W-1:0] I_RD_ADDR0;
  logic [ADDR_W-1:0] I_RD_ADDR1;
  logic [ADDR_W-1:0] I_RD_ADDR2;
  logic [ADDR_W-1:0] I_RD_ADDR3;
  logic [7:0]        O_RD_DATA0;
  logic [7:0]        O_RD_DATA1;
  logic [7:0]        O_RD_DATA2;
  logic [7:0]        O_RD_DATA3;
  logic              O_RD_VALID;
  logic              O_RD_ERR;
  logic              I_DONE;
  logic              O_BUSY;

  modport master (
    output I_START, I_FILL_LEN, I_WR_VALID, I_WR_DATA, I_RD_EN,
           I_RD_ADDR0, I_RD_ADDR1, I_RD_ADDR2, I_RD_ADDR3, I_DONE,
    input  O_WR_READY, O_DMA_READY, O_RD_DATA0, O_RD_DATA1, O_RD_DATA2,
           O_RD_DATA3, O_RD_VALID, O_RD_ERR, O_BUSY
  );

  modport slave (
    input  I_START, I_FILL_LEN, I_WR_VALID, I_WR_DATA, I_RD_EN,
           I_RD_ADDR0, I_RD_ADDR1, I_RD_ADDR2, I_RD_ADDR3, I_DONE,
    output O_WR_READY, O_DMA_READY, O_RD_DATA0, O_RD_DATA1, O_RD_DATA2,
           O_RD_DATA3, O_RD_VALID, O_RD_ERR, O_BUSY
  );
endinterface

// File: rtl/tile_mem_4r1w.sv
// 256x8 flop array with one 32-bit word write port and four registered byte read ports.
module tile_mem_4r1w
  import rotate_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               we,
  input  logic [WORD_W-1:0]                  waddr,
  input  logic [BEAT_W-1:0]                  wdata,
  input  logic                               rd_en,
  input  logic [RD_PORTS-1:0][ADDR_W-1:0]    raddr,
  output logic [RD_PORTS-1:0][7:0]           rdata_p1
);
  logic [7:0] mem [DEPTH];

  // Byte 0 of the beat lands on the lowest address of the word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < BYTES_PER_BEAT; k++) begin
        mem[{waddr, 2'(k)}] <= wdata[8*k +: 8];
      end
    end
  end

  // Stage p0 -> p1: non-blocking read of mem gives read-before-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_p1 <= '0;
    end else if (rd_en) begin
      for (int k = 0; k < RD_PORTS; k++) begin
        rdata_p1[k] <= mem[raddr[k]];
      end
    end
  end
endmodule

// File: rtl/core_tile_buf.sv
// Pixel tile buffer: DMA fills a tile, core_pixel reads four bytes per cycle until it releases it.
module core_tile_buf
  import rotate_pkg::*;
(
  input  logic            I_HCLK,
  input  logic            I_HRESET,
  core_tile_buf_if.slave  bus
);
  state_t                          state, state_nxt;
  logic [LEN_W-1:0]                len_q;
  logic [WPTR_W-1:0]               wptr;
  logic [LEN_W-1:0]                beat_end;
  logic                            wr_ready, dma_ready, busy;
  logic                            wr_fire, last_beat;
  logic [RD_PORTS-1:0][ADDR_W-1:0] raddr;
  logic [RD_PORTS-1:0][7:0]        rdata_p1;
  logic                            err_p0, err_p1, vld_p1;

  assign wr_fire   = bus.I_WR_VALID && wr_ready;
  assign beat_end  = LEN_W'({wptr, 2'b00}) + LEN_W'(BYTES_PER_BEAT);
  assign last_beat = wr_fire && (beat_end == len_q);

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    dma_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.I_START) state_nxt = FILL;
      end
      FILL: begin
        busy     = 1'b1;
        // A zero-length tile accepts nothing and completes after one cycle.
        wr_ready = (len_q != '0);
        if (bus.I_START)                       state_nxt = FILL;
        else if (len_q == '0 || last_beat)     state_nxt = READY;
      end
      READY: begin
        busy      = 1'b1;
        dma_ready = 1'b1;
        if (bus.I_START)     state_nxt = FILL;
        else if (bus.I_DONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_HCLK or posedge I_HRESET) begin
    if (I_HRESET) begin
      state <= IDLE;
      len_q <= '0;
      wptr  <= '0;
    end else begin
      state <= state_nxt;
      if (bus.I_START) begin
        len_q <= bus.I_FILL_LEN;
        wptr  <= '0;
      end else if (wr_fire) begin
        wptr <= wptr + 1'b1;
      end
    end
  end

  assign raddr = {bus.I_RD_ADDR3, bus.I_RD_ADDR2, bus.I_RD_ADDR1, bus.I_RD_ADDR0};

  always_comb begin
    err_p0 = 1'b0;
    for (int k = 0; k < RD_PORTS; k++) begin
      if ({1'b0, raddr[k]} >= len_q) err_p0 = 1'b1;
    end
  end

  // Stage p0 -> p1: read status travels with the registered read data.
  always_ff @(posedge I_HCLK or posedge I_HRESET) begin
    if (I_HRESET) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.I_RD_EN;
      err_p1 <= bus.I_RD_EN && err_p0;
    end
  end

  tile_mem_4r1w u_mem (
    .clk      (I_HCLK),
    .rst      (I_HRESET),
    .we       (wr_fire),
    .waddr    (wptr[WORD_W-1:0]),
    .wdata    (bus.I_WR_DATA),
    .rd_en    (bus.I_RD_EN),
    .raddr    (raddr),
    .rdata_p1 (rdata_p1)
  );

  assign bus.O_WR_READY  = wr_ready;
  assign bus.O_DMA_READY = dma_ready;
  assign bus.O_BUSY      = busy;
  assign bus.O_RD_VALID  = vld_p1;
  assign bus.O_RD_ERR    = err_p1;
  assign bus.O_RD_DATA0  = rdata_p1[0];
  assign bus.O_RD_DATA1  = rdata_p1[1];
  assign bus.O_RD_DATA2  = rdata_p1[2];
  assign bus.O_RD_DATA3  = rdata_p1[3];
endmodule

// File: doc/core_tile_buf.md
Name: core_tile_buf

Overview:
- Pixel tile buffer on the data side of the rotate core's address interface; `core_pixel` drives the addresses.
- Accepts a tile of pixel bytes from the DMA write path, then asserts the ready flag that feeds `core_pixel`'s `I_DMA_READY`.
- Services four parallel read addresses per cycle (`O_PIXEL_IN_ADDR0..3`) with registered read data.
- Sits between the AHB DMA engine and `core_pixel`.

Parameters:
- ADDR_W, 8, pixel address width; matches the `core_pixel` address buses.
- DEPTH, 256, buffer entries in bytes; equals 2**ADDR_W.
- BEAT_W, 32, DMA write beat width; 4 bytes per beat.

Ports:
- I_HCLK  in  1  system clock; all logic on the rising edge.
- I_HRESET  in  1  asynchronous, active-high reset.
- I_START  in  1  one-cycle pulse; begins a new tile fill.
- I_FILL_LEN  in  9  tile length in bytes, 0..256; must be a multiple of 4; sampled on I_START.
- I_WR_VALID  in  1  DMA write beat valid.
- I_WR_DATA  in  32  beat data; byte 0 in [7:0] goes to the lowest address.
- O_WR_READY  out  1  buffer accepts a beat this cycle.
- O_DMA_READY  out  1  tile is loaded; drives `core_pixel` `I_DMA_READY`.
- I_RD_EN  in  1  read request for the four addresses.
- I_RD_ADDR0..I_RD_ADDR3  in  8 each  read addresses, driven from `O_PIXEL_IN_ADDR0..3`.
- O_RD_DATA0..O_RD_DATA3  out  8 each  read data, valid when O_RD_VALID is high.
- O_RD_VALID  out  1  read data valid; one cycle after I_RD_EN.
- O_RD_ERR  out  1  set alongside O_RD_VALID when any address is >= the loaded length.
- I_DONE  in  1  pulse from the core after the last pixel; releases the tile.
- O_BUSY  out  1  high in the FILL and READY states.

Behaviour:
- Reset (asynchronous, I_HRESET=1):
  - State goes to IDLE; all outputs are 0; fill counter is 0; loaded length is 0.
  - Memory contents are not reset.
- IDLE:
  - O_WR_READY=0 and O_DMA_READY=0.
  - I_START latches I_FILL_LEN into len_q, clears wptr (a 7-bit word counter) and moves to FILL.
- FILL:
  - O_WR_READY=1.
  - On I_WR_VALID && O_WR_READY, bytes wptr*4+0..3 are written and wptr increments.
  - When (wptr+1)*4 == len_q on an accepted beat, the state moves to READY on the next edge; O_WR_READY drops in that same edge.
  - With len_q==0, FILL moves to READY after one cycle and no beats are accepted.
  - Beats presented outside FILL are not accepted; they are not an error.
- READY:
  - O_DMA_READY=1 and O_WR_READY=0.
  - I_DONE moves the state to IDLE; O_DMA_READY falls on the next edge.
  - I_START reloads: len_q is relatched and the state moves to FILL.
- Read port:
  - Active in any state; it is not gated by state.
  - I_RD_EN at cycle N: O_RD_DATAk = mem[I_RD_ADDRk] and O_RD_VALID=1 at N+1.
  - O_RD_DATAk holds its last value when I_RD_EN=0; O_RD_VALID=0 in that case.
  - O_RD_ERR at N+1 = I_RD_EN && any(I_RD_ADDRk >= len_q); the compare is 9-bit unsigned.
  - Identical addresses on several ports return the same byte.
- Simultaneous events:
  - I_START with I_DONE: I_START wins.
  - Read and write in the same cycle to the same address: the read returns the old byte (read-before-write).
  - I_START in FILL restarts the fill; the partial tile is discarded.
- Reset mid-fill: the state returns to IDLE and the next I_START must refill the tile.
- Reset mid-read: O_RD_VALID clears immediately (asynchronous).
- Latency:
  - Fill of L bytes: O_DMA_READY is high L/4+1 cycles after I_START, with I_WR_VALID held high.
  - Read latency is 1 cycle.

Decomposition:
- Shared package `rotate_pkg` holds:
  - state encoding (IDLE=2'd0, FILL=2'd1, READY=2'd2);
  - ADDR_W, DEPTH and BYTES_PER_BEAT=4.
- One sub-module, `tile_mem_4r1w`:
  - 256x8 flop array;
  - one 32-bit word write port;
  - four registered 8-bit read ports, read-before-write.
- The FSM, counters and error compare live in the top level.

Test Plan:
- Basic 8x8x3 load: reset, I_START with I_FILL_LEN=192, 48 beats of 0x03020100+0x04040404*i.
  - O_DMA_READY rises 49 cycles after I_START.
  - Reading addresses 0,1,2,191 returns 0x00,0x01,0x02,0xBF with O_RD_VALID a cycle later.
- Bounds error: with len 192 loaded, read addresses 191,192,0,255.
  - Data is returned and O_RD_ERR=1.
  - Reading 0,1,2,3 gives O_RD_ERR=0.
- Back-pressure-free idle: drive I_WR_VALID in IDLE and READY.
  - O_WR_READY=0 throughout; memory is unchanged (read back and compare).
- Release and reload: I_DONE in READY gives O_DMA_READY=0 next cycle.
  - I_START with len 16 and four beats gives READY after 5 cycles.
  - I_START and I_DONE together enter FILL.
- Mid-fill reset: assert I_HRESET after 10 beats of a 256-byte fill.
  - All outputs are 0 asynchronously and the state is IDLE.
  - A full refill afterwards works.
- Edge lengths: I_FILL_LEN=0 gives READY one cycle after FILL entry.
  - I_FILL_LEN=256 gives 64 beats; address 255 reads its last byte with O_RD_ERR=0.
